// File: rtl/pipe_pkg.sv
// Shared types and constants for the generic elastic pipeline-stage register.
// Provides the stage state encoding, occupancy codes, the RV32 NOP used as
// the bubble payload and a state-to-occupancy helper.
package pipe_pkg;

  localparam int unsigned OCC_W = 2;

  typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_TWO} pipe_state_t;

  localparam logic [OCC_W-1:0] OCC_EMPTY = 2'd0;
  localparam logic [OCC_W-1:0] OCC_ONE   = 2'd1;
  localparam logic [OCC_W-1:0] OCC_TWO   = 2'd2;

  // addi x0, x0, 0
  localparam logic [31:0] RV_NOP = 32'h0000_0013;

  // Number of entries held in a given state
  function automatic logic [OCC_W-1:0] occ_of(input pipe_state_t s);
    case (s)
      ST_ONE:  return OCC_ONE;
      ST_TWO:  return OCC_TWO;
      default: return OCC_EMPTY;
    endcase
  endfunction

endpackage

// File: rtl/pipe_stage_entry.sv
// One payload storage entry of a pipeline stage.
// Ports: clk, rst_n (async active-low), clear_i (load BUBBLE_VALUE, wins over
// load), load_i (capture d_i), d_i payload in, q_o stored payload.
module pipe_stage_entry
  import pipe_pkg::*;
#(
  parameter int unsigned      WIDTH        = 32,
  parameter logic [WIDTH-1:0] BUBBLE_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] data_d;
  logic [WIDTH-1:0] data_q;

  // Next payload: clear beats load, otherwise hold
  always_comb begin
    data_d = data_q;
    if (clear_i) begin
      data_d = BUBBLE_VALUE;
    end else if (load_i) begin
      data_d = d_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= BUBBLE_VALUE;
    end else begin
      data_q <= data_d;
    end
  end

  assign q_o = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic valid/ready pipeline-stage register with optional two-entry skid
// buffer, global BUSYWAIT stall and synchronous FLUSH to a bubble.
// Ports: CLK, RESET (async active-low), BUSYWAIT (freeze), FLUSH (kill),
// IN_VALID/IN_READY/IN_DATA upstream, OUT_VALID/OUT_READY/OUT_DATA
// downstream, OCCUPANCY entries held (0..2).
// IN_READY is combinational from flops plus BUSYWAIT/FLUSH (and OUT_READY
// when SKID=0); OUT_VALID/OCCUPANCY are flops.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned      WIDTH        = 32,
  parameter int unsigned      SKID         = 1,
  parameter logic [WIDTH-1:0] BUBBLE_VALUE = '0
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             BUSYWAIT,
  input  logic             FLUSH,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] IN_DATA,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] OUT_DATA,
  output logic [OCC_W-1:0] OCCUPANCY
);

  localparam bit HAS_SKID = (SKID != 0);

  logic [1:0]       rst_sync_d;
  logic [1:0]       rst_sync_q;
  logic             released;

  pipe_state_t      state_d;
  pipe_state_t      state_q;
  logic             valid_d;
  logic             valid_q;
  logic [OCC_W-1:0] occ_d;
  logic [OCC_W-1:0] occ_q;

  logic             in_ready_c;
  logic             in_fire;
  logic             out_fire;
  logic             head_load;
  logic             head_from_skid;
  logic             skid_load;
  logic [WIDTH-1:0] head_in;
  logic [WIDTH-1:0] head_q;
  logic [WIDTH-1:0] skid_q;

  // Two-flop reset release: IN_READY stays low until the second edge
  assign rst_sync_d = {rst_sync_q[0], 1'b1};

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      rst_sync_q <= '0;
    end else begin
      rst_sync_q <= rst_sync_d;
    end
  end

  assign released = rst_sync_q[1];

  // Upstream ready and handshake qualification
  always_comb begin
    in_ready_c = 1'b0;
    if (HAS_SKID) begin
      in_ready_c = (state_q != ST_TWO);
    end else begin
      in_ready_c = (state_q == ST_EMPTY) || OUT_READY;
    end
    in_ready_c = in_ready_c && !BUSYWAIT && !FLUSH && released;
  end

  assign in_fire  = IN_VALID && in_ready_c;
  assign out_fire = valid_q && OUT_READY && !BUSYWAIT;

  // Next state and payload-load controls; FLUSH overrides everything
  always_comb begin
    state_d        = state_q;
    head_load      = 1'b0;
    head_from_skid = 1'b0;
    skid_load      = 1'b0;
    if (FLUSH) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            state_d   = ST_ONE;
            head_load = 1'b1;
          end
        end
        ST_ONE: begin
          if (in_fire && out_fire) begin
            head_load = 1'b1;
          end else if (in_fire) begin
            // Only reachable with a skid entry: SKID=0 needs OUT_READY to accept
            if (HAS_SKID) begin
              state_d   = ST_TWO;
              skid_load = 1'b1;
            end
          end else if (out_fire) begin
            state_d = ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (out_fire) begin
            state_d        = ST_ONE;
            head_load      = 1'b1;
            head_from_skid = 1'b1;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
    valid_d = (state_d != ST_EMPTY);
    occ_d   = occ_of(state_d);
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= ST_EMPTY;
      valid_q <= 1'b0;
      occ_q   <= OCC_EMPTY;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      occ_q   <= occ_d;
    end
  end

  assign head_in = head_from_skid ? skid_q : IN_DATA;

  pipe_stage_entry #(
    .WIDTH        (WIDTH),
    .BUBBLE_VALUE (BUBBLE_VALUE)
  ) u_head (
    .clk     (CLK),
    .rst_n   (RESET),
    .clear_i (FLUSH),
    .load_i  (head_load),
    .d_i     (head_in),
    .q_o     (head_q)
  );

  generate
    if (HAS_SKID) begin : g_skid
      pipe_stage_entry #(
        .WIDTH        (WIDTH),
        .BUBBLE_VALUE (BUBBLE_VALUE)
      ) u_skid (
        .clk     (CLK),
        .rst_n   (RESET),
        .clear_i (FLUSH),
        .load_i  (skid_load),
        .d_i     (IN_DATA),
        .q_o     (skid_q)
      );
    end else begin : g_no_skid
      // Single-entry stage: skid storage collapses to the bubble constant
      logic skid_load_unused;
      assign skid_load_unused = skid_load;
      assign skid_q           = BUBBLE_VALUE;
    end
  endgenerate

  assign IN_READY  = in_ready_c;
  assign OUT_VALID = valid_q;
  assign OUT_DATA  = head_q;
  assign OCCUPANCY = occ_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: SKID=1 instance (IF/ID style, NOP
// bubble) and SKID=0 instance with a scoreboard-checked random stream.
module tb_pipe_stage_reg;
  import pipe_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // SKID=1 instance
  logic        a_busy, a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [31:0] a_in_data, a_out_data;
  logic [1:0]  a_occ;

  // SKID=0 instance
  logic        b_busy, b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [15:0] b_in_data, b_out_data;
  logic [1:0]  b_occ;

  int n_checks = 0;
  int n_errors = 0;

  pipe_stage_reg #(
    .WIDTH        (32),
    .SKID         (1),
    .BUBBLE_VALUE (RV_NOP)
  ) u_a (
    .CLK       (clk),
    .RESET     (rst_n),
    .BUSYWAIT  (a_busy),
    .FLUSH     (a_flush),
    .IN_VALID  (a_in_valid),
    .IN_READY  (a_in_ready),
    .IN_DATA   (a_in_data),
    .OUT_VALID (a_out_valid),
    .OUT_READY (a_out_ready),
    .OUT_DATA  (a_out_data),
    .OCCUPANCY (a_occ)
  );

  pipe_stage_reg #(
    .WIDTH        (16),
    .SKID         (0),
    .BUBBLE_VALUE (16'h0000)
  ) u_b (
    .CLK       (clk),
    .RESET     (rst_n),
    .BUSYWAIT  (b_busy),
    .FLUSH     (b_flush),
    .IN_VALID  (b_in_valid),
    .IN_READY  (b_in_ready),
    .IN_DATA   (b_in_data),
    .OUT_VALID (b_out_valid),
    .OUT_READY (b_out_ready),
    .OUT_DATA  (b_out_data),
    .OCCUPANCY (b_occ)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Advance past the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Check the SKID=1 registered outputs
  task automatic chk_a(input string tag, input logic v, input logic [1:0] occ,
                       input logic [31:0] data);
    chk({tag, ".valid"}, 32'(a_out_valid), 32'(v));
    chk({tag, ".occ"},   32'(a_occ),       32'(occ));
    chk({tag, ".data"},  a_out_data,       data);
  endtask

  logic [15:0] sb_q[$];
  int          sent;
  int          rcvd;
  logic        exp_rdy;
  logic        m_in_fire;
  logic        m_out_fire;

  initial begin
    rst_n       = 1'b0;
    a_busy      = 1'b0; a_flush = 1'b0; a_out_ready = 1'b0;
    a_in_valid  = 1'b1; a_in_data = 32'h55;
    b_busy      = 1'b0; b_flush = 1'b0; b_out_ready = 1'b0;
    b_in_valid  = 1'b0; b_in_data = 16'h0;

    // Reset held with IN_VALID=1
    repeat (3) tick();
    chk_a("rst", 1'b0, 2'd0, 32'h13);
    chk("rst.in_ready", 32'(a_in_ready), 32'd0);
    rst_n      = 1'b1;
    a_in_valid = 1'b0;
    tick();
    chk("rel1.in_ready", 32'(a_in_ready), 32'd0);
    tick();
    chk("rel2.in_ready", 32'(a_in_ready), 32'd1);

    // Streaming 1..8, one per cycle
    a_out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      a_in_valid = 1'b1;
      a_in_data  = 32'(i);
      #1;
      chk($sformatf("stream%0d.in_ready", i), 32'(a_in_ready), 32'd1);
      tick();
      chk_a($sformatf("stream%0d", i), 1'b1, 2'd1, 32'(i));
    end
    a_in_valid = 1'b0;
    tick();
    chk_a("stream.drain", 1'b0, 2'd0, 32'h8);

    // Backpressure: A, B fill both entries, C waits upstream
    a_out_ready = 1'b0;
    a_in_valid  = 1'b1;
    a_in_data   = 32'hA;
    tick();
    chk_a("bp.A", 1'b1, 2'd1, 32'hA);
    a_in_data = 32'hB;
    #1;
    chk("bp.B.in_ready", 32'(a_in_ready), 32'd1);
    tick();
    chk_a("bp.B", 1'b1, 2'd2, 32'hA);
    a_in_data = 32'hC;
    #1;
    chk("bp.C.in_ready", 32'(a_in_ready), 32'd0);
    tick();
    chk_a("bp.hold", 1'b1, 2'd2, 32'hA);
    a_out_ready = 1'b1;
    #1;
    chk("bp.two.in_ready", 32'(a_in_ready), 32'd0);
    tick();
    chk_a("bp.outA", 1'b1, 2'd1, 32'hB);
    chk("bp.one.in_ready", 32'(a_in_ready), 32'd1);
    tick();
    chk_a("bp.outB", 1'b1, 2'd1, 32'hC);
    a_in_valid = 1'b0;
    tick();
    chk_a("bp.outC", 1'b0, 2'd0, 32'hC);

    // BUSYWAIT freeze with two entries
    a_out_ready = 1'b0;
    a_in_valid  = 1'b1;
    a_in_data   = 32'h21;
    tick();
    a_in_data = 32'h22;
    tick();
    a_in_valid  = 1'b0;
    a_out_ready = 1'b1;
    a_busy      = 1'b1;
    a_in_valid  = 1'b1;
    a_in_data   = 32'h99;
    #1;
    chk("bw.in_ready", 32'(a_in_ready), 32'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_a($sformatf("bw%0d", i), 1'b1, 2'd2, 32'h21);
    end
    a_busy     = 1'b0;
    a_in_valid = 1'b0;
    tick();
    chk_a("bw.rel1", 1'b1, 2'd1, 32'h22);
    tick();
    chk_a("bw.rel2", 1'b0, 2'd0, 32'h22);

    // FLUSH beats BUSYWAIT and the pending input
    a_out_ready = 1'b0;
    a_in_valid  = 1'b1;
    a_in_data   = 32'h31;
    tick();
    a_in_data = 32'h32;
    tick();
    chk("fl.pre.occ", 32'(a_occ), 32'd2);
    a_flush     = 1'b1;
    a_busy      = 1'b1;
    a_out_ready = 1'b1;
    a_in_data   = 32'h33;
    #1;
    chk("fl.in_ready", 32'(a_in_ready), 32'd0);
    tick();
    a_flush = 1'b0;
    a_busy  = 1'b0;
    a_in_data = 32'h44;
    chk_a("fl.post", 1'b0, 2'd0, 32'h13);
    tick();
    a_in_valid = 1'b0;
    chk_a("fl.next", 1'b1, 2'd1, 32'h44);
    tick();
    chk_a("fl.drain", 1'b0, 2'd0, 32'h44);

    // SKID=0: OUT_READY toggles each cycle, random 100-item stream
    sent = 0;
    rcvd = 0;
    for (int cyc = 0; cyc < 2000 && rcvd < 100; cyc++) begin
      b_out_ready = cyc[0];
      b_in_valid  = (sent < 100) ? 1'($urandom_range(0, 1)) : 1'b0;
      b_in_data   = 16'($urandom);
      #1;
      exp_rdy    = (sb_q.size() == 0) || b_out_ready;
      m_out_fire = (sb_q.size() != 0) && b_out_ready;
      m_in_fire  = b_in_valid && exp_rdy;
      chk("s0.in_ready", 32'(b_in_ready), 32'(exp_rdy));
      chk("s0.valid", 32'(b_out_valid), 32'(sb_q.size() != 0));
      if (m_out_fire) begin
        chk($sformatf("s0.data%0d", rcvd), 32'(b_out_data), 32'(sb_q[0]));
        void'(sb_q.pop_front());
        rcvd++;
      end
      if (m_in_fire) begin
        sb_q.push_back(b_in_data);
        sent++;
      end
      tick();
    end
    chk("s0.rcvd", 32'(rcvd), 32'd100);
    b_in_valid  = 1'b0;
    b_out_ready = 1'b0;

    // Asynchronous reset mid-operation
    a_out_ready = 1'b0;
    a_in_valid  = 1'b1;
    a_in_data   = 32'h77;
    tick();
    chk_a("mr.pre", 1'b1, 2'd1, 32'h77);
    #2;
    rst_n = 1'b0;
    #1;
    chk_a("mr.rst", 1'b0, 2'd0, 32'h13);
    chk("mr.in_ready", 32'(a_in_ready), 32'd0);
    tick();
    rst_n = 1'b1;
    a_in_valid = 1'b0;
    repeat (2) tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised elastic pipeline-stage register for the RV32IM pipeline. It replaces the fixed IF/ID, ID/EX, EX/MEM and MEM/WB registers with one generic block carrying a WIDTH-bit packed payload. The block uses a valid/ready handshake, an optional two-entry skid buffer for full throughput with registered ready, a global BUSYWAIT stall and a synchronous FLUSH that inserts a bubble. Each pipeline boundary instantiates one copy, and the core packs its control and data fields into the payload.

## Interface
- WIDTH, 32: payload width in bits (1..256).
- SKID, 1: 1 gives a two-entry skid buffer with IN_READY driven only by flops and BUSYWAIT/FLUSH. 0 gives a single entry with a combinational OUT_READY→IN_READY path.
- BUBBLE_VALUE, {WIDTH{1'b0}}: payload loaded on reset and on flush. It encodes a NOP, for example 32'h00000013 for the IF/ID instance.
- CLK  in  1  clock; all state updates on the rising edge.
- RESET  in  1  asynchronous, active-low reset.
- BUSYWAIT  in  1  global stall from memory. While 1, no transfer on either side and state is frozen.
- FLUSH  in  1  synchronous kill (branch/jump taken). Discards all held entries.
- IN_VALID  in  1  upstream has data.
- IN_READY  out  1  block accepts data this cycle.
- IN_DATA  in  WIDTH  upstream payload.
- OUT_VALID  out  1  head entry is valid.
- OUT_READY  in  1  downstream accepts data.
- OUT_DATA  out  WIDTH  head payload.
- OCCUPANCY  out  2  entries held (0..2; max 1 when SKID=0).

## Operation
- Input fire: IN_VALID & IN_READY.
- Output fire: OUT_VALID & OUT_READY & ~BUSYWAIT.
- SKID=1 FSM states: EMPTY, ONE, TWO. Storage is a head register (drives OUT_DATA) and a skid register.
  - EMPTY: input fire → ONE, head ← IN_DATA.
  - ONE, input and output fire: stay ONE, head ← IN_DATA.
  - ONE, input fire only: → TWO, skid ← IN_DATA.
  - ONE, output fire only: → EMPTY.
  - TWO: IN_READY=0. Output fire → ONE, head ← skid.
  - SKID=1 IN_READY = (state≠TWO) & ~BUSYWAIT & ~FLUSH & reset released.
- SKID=0 FSM states: EMPTY and ONE only.
  - IN_READY = (state=EMPTY | OUT_READY) & ~BUSYWAIT & ~FLUSH & reset released.
  - Simultaneous input and output fire reloads head and stays in ONE.
- BUSYWAIT=1: both fires are suppressed. State, head, skid and OUT_VALID hold. OUT_DATA is stable.
- FLUSH=1 takes priority over BUSYWAIT and over all fires:
  - next state EMPTY;
  - head and skid ← BUBBLE_VALUE;
  - IN_READY is forced 0, so no accepted data is ever lost silently.
  - An output fire in the flush cycle still counts as delivered.
- Payload registers load only on fire, flush or reset. Draining to EMPTY leaves head unchanged; OUT_DATA is don't-care while OUT_VALID=0.
- OUT_VALID = (state≠EMPTY). It is a pure flop output and is never gated by BUSYWAIT. Downstream must qualify with BUSYWAIT itself.
- OCCUPANCY: EMPTY=0, ONE=1, TWO=2, registered.

## Timing
- Reset (RESET=0, asynchronous) immediately drives:
  - state EMPTY, OUT_VALID=0, OCCUPANCY=0;
  - OUT_DATA=BUBBLE_VALUE, skid=BUBBLE_VALUE;
  - IN_READY=0.
- Deassertion is synchronised through a 2-flop release. IN_READY may first rise on the second rising edge after RESET goes high.
- Reset mid-operation discards all entries without a handshake.
- Latency: input fire at edge N → OUT_VALID=1 with that payload after edge N, so it is visible in cycle N+1.
- Throughput: one transfer per cycle sustained in both SKID modes when OUT_READY=1 and BUSYWAIT=0.
- SKID=1: one OUT_READY low cycle costs no upstream bubble. IN_READY drops only after TWO is reached.
- Ordering is strictly FIFO. Nothing is duplicated or dropped except by FLUSH or reset.

## Structure
- Shared package pipe_pkg holds:
  - typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_TWO} pipe_state_t;
  - occupancy constants OCC_EMPTY/OCC_ONE/OCC_TWO;
  - the NOP constant RV_NOP = 32'h00000013.
- One sub-module, pipe_stage_entry: a WIDTH-bit register with load, clear-to-BUBBLE_VALUE and async reset. It is instantiated for head and, when SKID=1, for skid.

## Test plan
- Reset: hold RESET=0 with IN_VALID=1 → OUT_VALID=0, OUT_DATA=BUBBLE_VALUE, IN_READY=0. IN_READY=1 on the second edge after release.
- Streaming (SKID=1, OUT_READY=1): send 0x1..0x8 back-to-back → OUT_DATA 0x1..0x8 on consecutive cycles, one cycle after each input, no gaps.
- Backpressure: send 0xA,0xB,0xC with OUT_READY=0 → OCCUPANCY 1→2, IN_READY=0 after 0xB, 0xC held upstream. Raise OUT_READY → 0xA,0xB,0xC out in order.
- BUSYWAIT: assert for 5 cycles with OCCUPANCY=2 and OUT_READY=1 → no fires, OUT_DATA frozen. On release, two entries drain in order.
- Flush: OCCUPANCY=2, FLUSH=1 together with BUSYWAIT=1 and IN_VALID=1 → next cycle OCCUPANCY=0, OUT_VALID=0, OUT_DATA=BUBBLE_VALUE, input not accepted.
- SKID=0 instance: OUT_READY toggled every cycle → IN_READY follows OUT_READY combinationally, no data loss over a 100-item random stream checked by a scoreboard.
